adc_poll_scheduler: RTL



---
 rtl/adc_poll_scheduler_pkg.sv | 14 +
 rtl/adc_poll_scheduler_if.sv | 30 +++
 rtl/adc_poll_scheduler_poll_timer.sv | 26 ++
 rtl/adc_poll_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/adc_poll_scheduler_pkg.sv
// Shared definitions for the ADC poll scheduler: default bus width and FSM state type.
package adc_poll_scheduler_pkg;

    localparam int unsigned N_SRC_DEFAULT = 25;

    typedef enum logic [2:0] {
        StIdle,
        StWaitQuiet,
        StSendHi,
        StSendLo,
        StNext
    } state_e;

endpackage

// File: rtl/adc_poll_scheduler_if.sv
// Byte/strobe command path between cmd_decoder, the poll scheduler and the slave interfaces.
interface adc_poll_scheduler_if #(
    parameter int unsigned N_SRC = adc_poll_scheduler_pkg::N_SRC_DEFAULT
);

    logic [7:0]       host_data;
    logic [N_SRC-1:0] host_valid;
    logic             host_ready;
    logic [7:0]       out_data;
    logic [N_SRC-1:0] out_valid;

    // master: the decoder side feeding bytes in and watching the merged stream.
    modport master (
        output host_data,
        output host_valid,
        input  host_ready,
        input  out_data,
        input  out_valid
    );

    // slave: the scheduler itself.
    modport slave (
        input  host_data,
        input  host_valid,
        output host_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/adc_poll_scheduler_poll_timer.sv
// Poll period down-counter: reloads on expiry, held at reload while disabled.
module adc_poll_scheduler_poll_timer #(
    parameter int unsigned PERIOD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic expire
);

    localparam int unsigned TimerW = $clog2(PERIOD_CYCLES);
    localparam logic [TimerW-1:0] Reload = TimerW'(PERIOD_CYCLES - 1);

    logic [TimerW-1:0] timer_q;

    assign expire = enable && (timer_q == '0);

    always_ff @(posedge clk) begin
        if (rst || !enable || expire) begin
            timer_q <= Reload;
        end else begin
            timer_q <= timer_q - TimerW'(1);
        end
    end

endmodule

// File: rtl/adc_poll_scheduler.sv
// Merges periodic two-byte ADC poll frames into the host command stream; frames are atomic
// and only start after the host has been idle for GAP_CYCLES.
module adc_poll_scheduler
    import adc_poll_scheduler_pkg::*;
#(
    parameter int unsigned N_SRC         = N_SRC_DEFAULT,
    parameter int unsigned N_CH          = 3,
    parameter int unsigned FIRST_ADDR    = 4,
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [15:0]         poll_word,
    adc_poll_scheduler_if.slave bus,
    output logic                busy,
    output logic [15:0]         poll_count,
    output logic                overrun
);

    localparam int unsigned ChW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned QuietW = $clog2(GAP_CYCLES + 1);
    localparam logic [ChW-1:0]    LastCh   = ChW'(N_CH - 1);
    localparam logic [QuietW-1:0] QuietMax = QuietW'(GAP_CYCLES);

    state_e            state_q;
    logic [ChW-1:0]    channel_q;
    logic [QuietW-1:0] quiet_q;
    logic              pending_q;
    logic              overrun_q;
    logic [15:0]       word_q;
    logic [15:0]       poll_count_q;
    logic [7:0]        out_data_q;
    logic [N_SRC-1:0]  out_valid_q;

    logic             expire;
    logic             host_any;
    logic             in_frame;
    logic             pend_clr;
    logic [N_SRC-1:0] poll_mask;

    adc_poll_scheduler_poll_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_poll_timer (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .expire(expire)
    );

    always_comb begin
        host_any  = |bus.host_valid;
        in_frame  = (state_q == StSendHi) || (state_q == StSendLo);
        poll_mask = N_SRC'(1) << (FIRST_ADDR + 32'(channel_q));
        // Round ends (abort or final channel) release the pending request.
        pend_clr  = ((state_q == StWaitQuiet) && !enable) ||
                    ((state_q == StNext) && (!enable || (channel_q == LastCh)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            channel_q    <= '0;
            quiet_q      <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            word_q       <= '0;
            poll_count_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= '0;
        end else begin
            if (host_any) begin
                quiet_q <= '0;
            end else if (quiet_q != QuietMax) begin
                quiet_q <= quiet_q + QuietW'(1);
            end

            // A clear and a fresh expiry in the same cycle leave the new request standing.
            pending_q <= (pending_q && !pend_clr) || expire;
            if (expire && pending_q && !pend_clr) begin
                overrun_q <= 1'b1;
            end

            if (in_frame) begin
                out_data_q  <= (state_q == StSendHi) ? word_q[15:8] : word_q[7:0];
                out_valid_q <= poll_mask;
            end else begin
                out_data_q  <= bus.host_data;
                out_valid_q <= bus.host_valid;
            end

            unique case (state_q)
                StIdle: begin
                    if (pending_q && enable) begin
                        state_q   <= StWaitQuiet;
                        channel_q <= '0;
                    end
                end
                StWaitQuiet: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if ((quiet_q == QuietMax) && !host_any) begin
                        state_q <= StSendHi;
                        word_q  <= poll_word;
                    end
                end
                StSendHi: state_q <= StSendLo;
                StSendLo: state_q <= StNext;
                StNext: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (channel_q != LastCh) begin
                        channel_q <= channel_q + ChW'(1);
                        state_q   <= StWaitQuiet;
                    end else begin
                        state_q      <= StIdle;
                        poll_count_q <= poll_count_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.host_ready = !in_frame;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign busy           = pending_q || (state_q != StIdle);
    assign poll_count     = poll_count_q;
    assign overrun        = overrun_q;

endmodule
